// File: rtl/cpu_if_pkg.sv
// Shared types and defaults for the CPU-interface target responder.
package cpu_if_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRdWait   = 3'd1,
    StWrWait   = 3'd2,
    StComplete = 3'd3,
    StRelease  = 3'd4
  } state_e;

  localparam int unsigned DefRdWait = 2;
  localparam int unsigned DefWrWait = 1;
  localparam int unsigned CntW      = 4;

endpackage

// File: rtl/cpu_if_wait_cnt.sv
// Loadable down-counter that sets the number of wait states before completion.
module cpu_if_wait_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/cpu_if_target_responder.sv
// Register-file target on a busy/complete CPU bus with programmable read/write wait states.
module cpu_if_target_responder
  import cpu_if_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned RD_WAIT  = DefRdWait,
  parameter int unsigned WR_WAIT  = DefWrWait
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_busy,
  input  logic              write_busy,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              access_complete,
  output logic              error,
  output logic              target_busy
);

  localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CntW-1:0] RdLoad = CntW'(RD_WAIT);
  localparam logic [CntW-1:0] WrLoad = CntW'(WR_WAIT);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic            cnt_load;
  logic [CntW-1:0] cnt_load_val;
  logic            cnt_dec;
  logic [CntW-1:0] cnt_value;
  logic            cnt_zero;
  logic            mapped;
  logic [IdxW-1:0] idx;

  assign mapped = (32'(addr_q) < 32'(NUM_REGS));
  assign idx    = addr_q[IdxW-1:0];

  always_comb begin
    cnt_load     = (state_q == StIdle) && (read_busy || write_busy);
    cnt_load_val = write_busy ? WrLoad : RdLoad;
    cnt_dec      = ((state_q == StRdWait) && read_busy) ||
                   ((state_q == StWrWait) && write_busy);
  end

  cpu_if_wait_cnt #(
    .CNT_W(CntW)
  ) u_wait_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .dec     (cnt_dec),
    .value   (cnt_value),
    .zero    (cnt_zero)
  );

  // rdata/error/access_complete default to 0 every cycle and are only raised on entry to COMPLETE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      wdata_q         <= '0;
      rdata           <= '0;
      access_complete <= 1'b0;
      error           <= 1'b0;
      target_busy     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      access_complete <= 1'b0;
      rdata           <= '0;
      error           <= 1'b0;
      case (state_q)
        StIdle: begin
          if (write_busy) begin
            state_q     <= StWrWait;
            addr_q      <= addr;
            wdata_q     <= wdata;
            target_busy <= 1'b1;
          end else if (read_busy) begin
            state_q     <= StRdWait;
            addr_q      <= addr;
            target_busy <= 1'b1;
          end
        end
        StRdWait: begin
          if (!read_busy) begin
            state_q     <= StIdle;
            target_busy <= 1'b0;
          end else if (cnt_zero) begin
            state_q         <= StComplete;
            access_complete <= 1'b1;
            error           <= !mapped;
            rdata           <= mapped ? regs_q[idx] : '0;
          end
        end
        StWrWait: begin
          if (!write_busy) begin
            state_q     <= StIdle;
            target_busy <= 1'b0;
          end else if (cnt_zero) begin
            state_q         <= StComplete;
            access_complete <= 1'b1;
            error           <= !mapped;
            if (mapped) begin
              regs_q[idx] <= wdata_q;
            end
          end
        end
        StComplete: begin
          state_q <= StRelease;
        end
        StRelease: begin
          // Wait for the initiator to drop busy so a lingering request is not re-accepted.
          if (!read_busy && !write_busy) begin
            state_q     <= StIdle;
            target_busy <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          target_busy <= 1'b0;
        end
      endcase
    end
  end

  logic unused_cnt;
  assign unused_cnt = ^cnt_value;

endmodule

// File: tb/tb_cpu_if_target_responder.sv
// Directed self-checking bench for cpu_if_target_responder with default parameters.
module tb_cpu_if_target_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_busy;
  logic        write_busy;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        access_complete;
  logic        error;
  logic        target_busy;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_if_target_responder dut (
    .clk            (clk),
    .reset          (reset),
    .read_busy      (read_busy),
    .write_busy     (write_busy),
    .addr           (addr),
    .wdata          (wdata),
    .rdata          (rdata),
    .access_complete(access_complete),
    .error          (error),
    .target_busy    (target_busy)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access; exp_lat counts edges from the accepting edge to the completion edge.
  task automatic access(input string tag, input logic wr, input logic rd, input logic [3:0] a,
                        input logic [31:0] d, input int exp_lat, input bit chk_rd,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    bit seen;
    addr       = a;
    wdata      = d;
    write_busy = wr;
    read_busy  = rd;
    step();
    check1({tag, "_accept_busy"}, target_busy, 1'b1);
    addr  = ~a;
    wdata = ~d;
    n     = 0;
    seen  = 0;
    while (!seen && n < 20) begin
      step();
      n++;
      if (access_complete) seen = 1;
      else begin
        check32({tag, "_rdata_idle"}, rdata, 32'h0);
        check1({tag, "_err_idle"}, error, 1'b0);
      end
    end
    check32({tag, "_latency"}, 32'(n), 32'(exp_lat));
    if (chk_rd) check32({tag, "_rdata"}, rdata, exp_rdata);
    check1({tag, "_error"}, error, exp_err);
    write_busy = 1'b0;
    read_busy  = 1'b0;
    step();
    check1({tag, "_pulse_end"}, access_complete, 1'b0);
    check1({tag, "_release_busy"}, target_busy, 1'b1);
    step();
    check1({tag, "_idle"}, target_busy, 1'b0);
  endtask

  initial begin
    int n;
    bit seen;
    reset      = 1'b1;
    read_busy  = 1'b0;
    write_busy = 1'b0;
    addr       = '0;
    wdata      = '0;
    step();
    step();
    check1("rst_ac", access_complete, 1'b0);
    check1("rst_tb", target_busy, 1'b0);
    check32("rst_rdata", rdata, 32'h0);
    check1("rst_err", error, 1'b0);
    reset = 1'b0;
    step();

    access("rd5", 1'b0, 1'b1, 4'd5, 32'h0, 3, 1'b1, 32'h0, 1'b0);
    access("wr3", 1'b1, 1'b0, 4'd3, 32'hA5A5_0003, 2, 1'b0, 32'h0, 1'b0);
    access("rd3", 1'b0, 1'b1, 4'd3, 32'h0, 3, 1'b1, 32'hA5A5_0003, 1'b0);
    access("both1", 1'b1, 1'b1, 4'd1, 32'h0000_1234, 2, 1'b0, 32'h0, 1'b0);
    access("rd1", 1'b0, 1'b1, 4'd1, 32'h0, 3, 1'b1, 32'h0000_1234, 1'b0);
    access("wr12", 1'b1, 1'b0, 4'd12, 32'hDEAD_BEEF, 2, 1'b1, 32'h0, 1'b1);
    access("rd4", 1'b0, 1'b1, 4'd4, 32'h0, 3, 1'b1, 32'h0, 1'b0);
    access("rd12", 1'b0, 1'b1, 4'd12, 32'h0, 3, 1'b1, 32'h0, 1'b1);

    // read_busy held after completion must not retrigger
    addr      = 4'd3;
    read_busy = 1'b1;
    step();
    n    = 0;
    seen = 0;
    while (!seen && n < 20) begin
      step();
      n++;
      if (access_complete) seen = 1;
    end
    check32("hold_latency", 32'(n), 32'd3);
    check32("hold_rdata", rdata, 32'hA5A5_0003);
    for (int i = 0; i < 3; i++) begin
      step();
      check1("hold_no_pulse", access_complete, 1'b0);
      check1("hold_busy", target_busy, 1'b1);
    end
    read_busy = 1'b0;
    step();
    check1("hold_idle", target_busy, 1'b0);
    access("hold_rd1", 1'b0, 1'b1, 4'd1, 32'h0, 3, 1'b1, 32'h0000_1234, 1'b0);

    // abort: write_busy dropped during WR_WAIT
    addr       = 4'd2;
    wdata      = 32'h0000_0077;
    write_busy = 1'b1;
    step();
    check1("abort_accept", target_busy, 1'b1);
    write_busy = 1'b0;
    step();
    check1("abort_idle", target_busy, 1'b0);
    check1("abort_ac0", access_complete, 1'b0);
    step();
    check1("abort_ac1", access_complete, 1'b0);
    step();
    check1("abort_ac2", access_complete, 1'b0);
    access("abort_rd2", 1'b0, 1'b1, 4'd2, 32'h0, 3, 1'b1, 32'h0, 1'b0);

    // reset during WR_WAIT
    addr       = 4'd6;
    wdata      = 32'h0000_0066;
    write_busy = 1'b1;
    step();
    check1("rstw_accept", target_busy, 1'b1);
    reset = 1'b1;
    step();
    check1("rstw_tb", target_busy, 1'b0);
    check1("rstw_ac", access_complete, 1'b0);
    reset      = 1'b0;
    write_busy = 1'b0;
    step();
    check1("rstw_ac1", access_complete, 1'b0);
    check1("rstw_tb1", target_busy, 1'b0);
    step();
    check1("rstw_ac2", access_complete, 1'b0);
    access("rstw_rd6", 1'b0, 1'b1, 4'd6, 32'h0, 3, 1'b1, 32'h0, 1'b0);
    access("rstw_rd3", 1'b0, 1'b1, 4'd3, 32'h0, 3, 1'b1, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
